// File: rtl/scan_display_pkg.sv
// Shared types and active-low seven-segment constants for the score display.
// Segment bit order is {g,f,e,d,c,b,a}; a 0 lights the segment.
package scan_display_pkg;

    typedef logic [3:0] bcd_digit_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;

    // Event amounts above a single decimal digit are limited to 9.
    function automatic bcd_digit_t sat_amt(input logic [3:0] amt);
        return (amt > 4'd9) ? 4'd9 : amt;
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// BCD digit to active-low seven-segment pattern; non-decimal codes show blank.
module seg7_decode
    import scan_display_pkg::*;
(
    input  bcd_digit_t  digit,
    output logic [6:0]  seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (digit)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/scan_score_display.sv
// BCD score counter with multiplexed seven-segment scan output.
// Define SCAN_SCORE_DISPLAY_BLANK_EN to blank leading zeros on positions above units.
module scan_score_display
    import scan_display_pkg::*;
#(
    parameter int unsigned DIGITS   = 4,
    parameter int unsigned SCAN_DIV = 50000,
    parameter int unsigned SAT      = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  score_inc,
    input  logic [3:0]            inc_amt,
    input  logic                  clr,
    input  logic                  game_end,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  ovf,
    output logic [DIGITS-1:0]     an,
    output logic [6:0]            seg
);

    localparam int unsigned DivW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned IdxW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [4*DIGITS-1:0] AllNines = {DIGITS{4'h9}};

    // ---------------------------------------------------------------
    // Score event detection
    // ---------------------------------------------------------------
    logic inc_q;
    logic inc_prev_q;
    logic armed_q;
    logic evt;

    // armed_q stays low until score_inc is seen low after reset, so a level
    // held through reset release never counts as an event.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inc_q      <= 1'b0;
            inc_prev_q <= 1'b0;
            armed_q    <= 1'b0;
        end else begin
            inc_q      <= score_inc;
            inc_prev_q <= inc_q;
            armed_q    <= armed_q | ~score_inc;
        end
    end

    assign evt = inc_q & ~inc_prev_q & armed_q;

    // ---------------------------------------------------------------
    // Decimal ripple adder
    // ---------------------------------------------------------------
    logic [4*DIGITS-1:0] bcd_q;
    logic [4*DIGITS-1:0] sum;
    logic [3:0]          carry;
    logic [4:0]          dsum;
    logic [4:0]          dwrap;
    logic                wrap;

    always_comb begin
        carry = sat_amt(inc_amt);
        sum   = bcd_q;
        dsum  = '0;
        dwrap = '0;
        for (int k = 0; k < int'(DIGITS); k++) begin
            dsum = {1'b0, bcd_q[4*k +: 4]} + {1'b0, carry};
            if (dsum > 5'd9) begin
                dwrap         = dsum - 5'd10;
                sum[4*k +: 4] = dwrap[3:0];
                carry         = 4'd1;
            end else begin
                sum[4*k +: 4] = dsum[3:0];
                carry         = 4'd0;
            end
        end
        wrap = (carry != 4'd0);
    end

    // ---------------------------------------------------------------
    // Score register: clr beats game_end beats a detected event
    // ---------------------------------------------------------------
    logic ovf_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bcd_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= 1'b0;
            if (clr) begin
                bcd_q <= '0;
            end else if (evt && !game_end) begin
                if (wrap) begin
                    ovf_q <= 1'b1;
                    bcd_q <= (SAT != 0) ? AllNines : sum;
                end else begin
                    bcd_q <= sum;
                end
            end
        end
    end

    // ---------------------------------------------------------------
    // Scan prescaler and digit index
    // ---------------------------------------------------------------
    logic [DivW-1:0] presc_q;
    logic [IdxW-1:0] idx_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q <= '0;
            idx_q   <= '0;
        end else if (presc_q == DivW'(SCAN_DIV - 1)) begin
            presc_q <= '0;
            idx_q   <= (idx_q == IdxW'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
        end else begin
            presc_q <= presc_q + 1'b1;
        end
    end

    // ---------------------------------------------------------------
    // Digit multiplexer, decoder and anode select
    // ---------------------------------------------------------------
    bcd_digit_t          cur_digit;
    logic [6:0]          dec_seg;
    logic [DIGITS-1:0]   an_d;
    logic                blank_now;

    always_comb begin
        cur_digit = '0;
        an_d      = '1;
        for (int k = 0; k < int'(DIGITS); k++) begin
            if (idx_q == IdxW'(k)) begin
                cur_digit = bcd_q[4*k +: 4];
                an_d[k]   = 1'b0;
            end
        end
    end

`ifdef SCAN_SCORE_DISPLAY_BLANK_EN
    logic [DIGITS-1:0] upper_zero;
    logic              run_zero;

    // upper_zero[k] is set when digit k and every digit above it are zero.
    always_comb begin
        run_zero   = 1'b1;
        upper_zero = '0;
        for (int k = int'(DIGITS) - 1; k >= 0; k--) begin
            run_zero      = run_zero && (bcd_q[4*k +: 4] == 4'd0);
            upper_zero[k] = run_zero;
        end
        blank_now = 1'b0;
        for (int k = 1; k < int'(DIGITS); k++) begin
            if (idx_q == IdxW'(k)) begin
                blank_now = upper_zero[k];
            end
        end
    end
`else
    assign blank_now = 1'b0;
`endif

    seg7_decode u_seg7_decode (
        .digit (cur_digit),
        .seg   (dec_seg)
    );

    logic [DIGITS-1:0] an_q;
    logic [6:0]        seg_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an_q  <= '1;
            seg_q <= SEG_BLANK;
        end else begin
            an_q  <= an_d;
            seg_q <= blank_now ? SEG_BLANK : dec_seg;
        end
    end

    assign bcd = bcd_q;
    assign ovf = ovf_q;
    assign an  = an_q;
    assign seg = seg_q;

endmodule

// File: tb/tb_scan_score_display.sv
// Scoreboard bench: a decimal-integer model predicts each score change, monitors
// compare every bcd change or ovf pulse of a wrap (SAT=0) and a clamp (SAT=1) instance.
module tb_scan_score_display;

    localparam int unsigned DIG    = 4;
    localparam int unsigned DIV    = 4;
    localparam int          MaxVal = 9999;

    logic       clk       = 1'b0;
    logic       rst_n     = 1'b1;
    logic       score_inc = 1'b0;
    logic [3:0] inc_amt   = 4'd0;
    logic       clr       = 1'b0;
    logic       game_end  = 1'b0;

    logic [15:0] bcd0, bcd1;
    logic        ovf0, ovf1;
    logic [3:0]  an0, an1;
    logic [6:0]  seg0, seg1;

    int checks = 0;
    int errors = 0;
    int val[2];
    logic [16:0] exp0[$];
    logic [16:0] exp1[$];

    always #5 clk = ~clk;

    scan_score_display #(.DIGITS(DIG), .SCAN_DIV(DIV), .SAT(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .score_inc(score_inc), .inc_amt(inc_amt), .clr(clr),
        .game_end(game_end), .bcd(bcd0), .ovf(ovf0), .an(an0), .seg(seg0)
    );

    scan_score_display #(.DIGITS(DIG), .SCAN_DIV(DIV), .SAT(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .score_inc(score_inc), .inc_amt(inc_amt), .clr(clr),
        .game_end(game_end), .bcd(bcd1), .ovf(ovf1), .an(an1), .seg(seg1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    function automatic logic [6:0] pat(input int d);
        case (d)
            0: return 7'h40;
            1: return 7'h79;
            2: return 7'h24;
            3: return 7'h30;
            4: return 7'h19;
            5: return 7'h12;
            6: return 7'h02;
            7: return 7'h78;
            8: return 7'h00;
            default: return 7'h10;
        endcase
    endfunction

    function automatic int pow10(input int p);
        int r = 1;
        for (int i = 0; i < p; i++) r = r * 10;
        return r;
    endfunction

    function automatic logic [6:0] exp_seg(input int value, input int p);
`ifdef SCAN_SCORE_DISPLAY_BLANK_EN
        if (p > 0 && value / pow10(p) == 0) return 7'h7F;
`endif
        return pat((value / pow10(p)) % 10);
    endfunction

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r = '0;
        int t = v;
        for (int k = 0; k < 4; k++) begin
            r[4*k +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    task automatic push(input int i, input logic [16:0] e);
        if (i == 0) exp0.push_back(e);
        else        exp1.push_back(e);
    endtask

    task automatic model_event(input int amt);
        int a = (amt > 9) ? 9 : amt;
        for (int i = 0; i < 2; i++) begin
            int n;
            bit ov;
            if (a != 0) begin
                n  = val[i] + a;
                ov = 1'b0;
                if (n > MaxVal) begin
                    ov = 1'b1;
                    n  = (i == 1) ? MaxVal : n - (MaxVal + 1);
                end
                if (n != val[i] || ov) push(i, {ov, to_bcd(n)});
                val[i] = n;
            end
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 2; i++) begin
            if (val[i] != 0) push(i, {1'b0, 16'h0000});
            val[i] = 0;
        end
    endtask

    task automatic monitor(input int i);
        logic [15:0] prev = '0;
        logic [15:0] b;
        logic        o;
        logic [16:0] e;
        int          depth;
        forever begin
            @(negedge clk);
            b = (i == 0) ? bcd0 : bcd1;
            o = (i == 0) ? ovf0 : ovf1;
            if (!rst_n) begin
                prev = '0;
            end else if (b !== prev || o !== 1'b0) begin
                depth = (i == 0) ? exp0.size() : exp1.size();
                if (depth == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output dut%0d: got bcd=%h ovf=%b, expected no change",
                             i, b, o);
                end else begin
                    e = (i == 0) ? exp0.pop_front() : exp1.pop_front();
                    check($sformatf("dut%0d_bcd", i), 32'(b), 32'(e[15:0]));
                    check($sformatf("dut%0d_ovf", i), 32'(o), 32'(e[16]));
                end
                prev = b;
            end
        end
    endtask

    initial monitor(0);
    initial monitor(1);

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse(input int amt, input int hi, input int lo, input bit modeled);
        inc_amt   = 4'(amt);
        score_inc = 1'b1;
        if (modeled) model_event(amt);
        tick(hi);
        score_inc = 1'b0;
        tick(lo);
    endtask

    task automatic do_clear();
        clr = 1'b1;
        model_clear();
        tick(1);
        clr = 1'b0;
        tick(1);
    endtask

    task automatic pump(input int target);
        do_clear();
        for (int j = 0; j < target / 9; j++) pulse(9, 1, 1, 1'b1);
        if (target % 9 != 0) pulse(target % 9, 1, 1, 1'b1);
        tick(2);
    endtask

    // Aligns to the start of position 0 and checks one full scan of a stable value.
    task automatic check_scan(input int value);
        logic [3:0] prev_an;
        logic [3:0] exp_an;
        int waited = 0;
        @(negedge clk);
        prev_an = an0;
        forever begin
            @(negedge clk);
            waited++;
            if (an0 == 4'b1110 && prev_an != 4'b1110) break;
            prev_an = an0;
            if (waited > int'(4 * DIG * DIV)) begin
                checks++;
                errors++;
                $display("FAIL scan_sync: got an=%b, expected a return to position 0", an0);
                return;
            end
        end
        for (int c = 0; c < int'(DIG * DIV); c++) begin
            int p = c / int'(DIV);
            if (c > 0) @(negedge clk);
            exp_an = ~(4'b0001 << p);
            check($sformatf("scan_an_p%0d", p), 32'(an0), 32'(exp_an));
            check($sformatf("scan_seg_p%0d", p), 32'(seg0), 32'(exp_seg(value, p)));
        end
    endtask

    // Call right after rst_n rises (just after a clk edge).
    task automatic check_scan_from_reset(input int value);
        logic [3:0] exp_an;
        @(posedge clk);
        for (int c = 0; c < int'(2 * DIG * DIV); c++) begin
            int p = (c / int'(DIV)) % int'(DIG);
            @(negedge clk);
            exp_an = ~(4'b0001 << p);
            check($sformatf("rst_scan_an_c%0d", c), 32'(an0), 32'(exp_an));
            check($sformatf("rst_scan_seg_c%0d", c), 32'(seg0), 32'(exp_seg(value, p)));
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_bcd0"}, 32'(bcd0), 32'h0);
        check({tag, "_bcd1"}, 32'(bcd1), 32'h0);
        check({tag, "_ovf0"}, 32'(ovf0), 32'h0);
        check({tag, "_an0"}, 32'(an0), 32'hF);
        check({tag, "_seg0"}, 32'(seg0), 32'h7F);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no end of stimulus, expected completion within 1 ms");
        $fatal(1, "watchdog expired");
    end

    initial begin
        val[0] = 0;
        val[1] = 0;
        #1 rst_n = 1'b0;
        #2 check_reset_outputs("por");
        tick(3);
        rst_n = 1'b1;
        check_scan_from_reset(0);

        // 98 plus five single steps: carries through two digits, no overflow
        pump(98);
        for (int j = 0; j < 5; j++) pulse(1, 1, 1, 1'b1);
        tick(2);
        check("inc_98_to_103", 32'(bcd0), 32'h0103);

        // 9998 + 3: wrap to 0001 or clamp at 9999, each with one ovf pulse
        pump(9998);
        pulse(3, 1, 2, 1'b1);
        tick(2);
        check("wrap_9998p3", 32'(bcd0), 32'h0001);
        check("clamp_9998p3", 32'(bcd1), 32'h9999);
        pulse(3, 1, 2, 1'b1);
        pulse(0, 1, 2, 1'b1);
        tick(2);
        check("clamp_hold", 32'(bcd1), 32'h9999);

        // Level held for 100 cycles counts once
        do_clear();
        inc_amt   = 4'd7;
        score_inc = 1'b1;
        model_event(7);
        tick(100);
        score_inc = 1'b0;
        tick(2);
        check("held_level_once", 32'(bcd0), 32'h0007);

        // Events during game_end are dropped, not replayed afterwards
        game_end = 1'b1;
        tick(1);
        for (int j = 0; j < 3; j++) pulse(5, 1, 1, 1'b0);
        tick(2);
        game_end = 1'b0;
        tick(3);
        check("game_end_ignored", 32'(bcd0), 32'h0007);

        // clr together with an event clears and suppresses the event
        inc_amt   = 4'd5;
        score_inc = 1'b1;
        clr       = 1'b1;
        model_clear();
        tick(2);
        clr       = 1'b0;
        score_inc = 1'b0;
        tick(3);
        check("clr_beats_event", 32'(bcd0), 32'h0000);

        pump(42);
        check_scan(42);
        pump(321);
        check_scan(321);

        // Async reset mid-scan with score_inc held high through release
        inc_amt   = 4'd0;
        score_inc = 1'b1;
        tick(3);
        #2 rst_n = 1'b0;
        val[0] = 0;
        val[1] = 0;
        #1 check_reset_outputs("async_rst");
        tick(2);
        inc_amt = 4'd4;
        rst_n   = 1'b1;
        check_scan_from_reset(0);
        check("held_through_reset", 32'(bcd0), 32'h0000);
        score_inc = 1'b0;
        tick(1);
        pulse(4, 1, 1, 1'b1);
        tick(2);
        check("rearm_after_reset", 32'(bcd0), 32'h0004);

        // Random traffic starting near the top so wraps and clamps recur
        pump(9950);
        for (int t = 0; t < 400; t++) begin
            int r = $urandom_range(0, 99);
            if (r < 85) begin
                pulse($urandom_range(0, 15), $urandom_range(1, 4), $urandom_range(1, 3), 1'b1);
            end else if (r < 89) begin
                do_clear();
            end else begin
                game_end = 1'b1;
                tick(1);
                pulse($urandom_range(0, 15), $urandom_range(1, 3), $urandom_range(1, 2), 1'b0);
                tick(2);
                game_end = 1'b0;
                tick(1);
            end
        end
        tick(3);
        check("rand_final_dut0", 32'(bcd0), 32'(to_bcd(val[0])));
        check("rand_final_dut1", 32'(bcd1), 32'(to_bcd(val[1])));
        check_scan(val[0]);

        tick(2);
        check("pending_dut0", 32'(exp0.size()), 32'd0);
        check("pending_dut1", 32'(exp1.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
